stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Stopwatch control core for the Nexys seven-segment display path. It synchronizes and debounces three raw push-buttons and runs a four-digit BCD time count, SS.hh from 00.00 to 99.99. The registered 16-bit BCD word feeds `sseg4_TDM.data` directly, with `hex_dec` driven for decimal display. It replaces the free-running `count_n` timer upstream of the display driver.

## Interface
- `TICK_DIV`, default 1_000_000: clk cycles per hundredth of a second (100 MHz → 100 Hz); ≥2.
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change (10 ms); ≥1.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_ss` in 1: raw start/stop button, asynchronous, active-high.
- `btn_lap` in 1: raw lap button, asynchronous, active-high.
- `btn_clr` in 1: raw clear button, asynchronous, active-high.
- `data` out 16: BCD time {S10, S1, H10, H1}, each nibble 0–9.
- `running` out 1: high in state RUN.
- `lapped` out 1: high while `data` is frozen at a lap value.

## Operation
- **Input conditioning, per button:**
  - 2-flop synchronizer.
  - Debounce counter: the debounced level takes the synchronized value once the synchronized value has differed from it for DB_CYCLES consecutive cycles. Any agreeing cycle zeroes the counter.
  - Press event: a 1-cycle pulse in the cycle the debounced level goes 0→1. Releases produce no event.
- **States:** IDLE (reset), RUN, STOP.
  - IDLE + ss event → RUN. The prescaler is zeroed on entry.
  - RUN + ss event → STOP. The prescaler holds its value.
  - STOP + ss event → RUN. The prescaler resumes from its held value.
  - STOP or IDLE + clr event → IDLE. Digits zeroed, prescaler zeroed, lap released.
  - clr in RUN is ignored.
- **Event priority in one cycle:** clr > ss > lap. Lower-priority events in the same cycle are dropped.
- **Lap:**
  - In RUN, a lap event toggles freeze. Set: the lap register captures the live digits and `lapped`=1. Clear: `lapped`=0.
  - In STOP, a lap event clears freeze only.
  - In IDLE, a lap event is ignored.
  - The live count keeps running while frozen.
- **Prescaler:** counts 0..TICK_DIV-1 only in RUN. A tick occurs in the cycle where it equals TICK_DIV-1; the prescaler then wraps to 0.
- **BCD increment on tick:** ripple carry H1 → H10 → S1 → S10. Each digit 9 → 0 with carry. 99.99 → 00.00 wraps silently, with no state change. Digits never hold values A–F.
- **Output:** `data` is registered as `lapped ? lap_reg : live`.

## Timing
- **Reset (cycle after `rst` sampled high):**
  - `data`=16'h0000, `running`=0, `lapped`=0, state IDLE.
  - All synchronizers, debounce counters, debounced levels, prescaler and lap register are zeroed.
  - `rst` has priority over every event, including mid-debounce and mid-count.
- **Button latency:** a raw 0→1 step held stable from cycle k gives a press event in cycle k+2+DB_CYCLES. The state and `running` update in the following cycle.
- **Glitches:** a raw pulse shorter than DB_CYCLES cycles produces no event.
- **Tick to output:** live digits update in the cycle after the tick. `data` follows one cycle later when not lapped, giving 2-cycle tick-to-`data` latency.
- **Lap to output:** the freeze takes effect on `data` 1 cycle after `lapped` sets. The captured value is the live digits at the lap-event cycle.
- **Stopped state:** in STOP, `data` holds exactly and no ticks occur.
- **Resume accuracy:** after a STOP/RUN pair, the next tick arrives after the remaining prescaler cycles, not a full period.

## Test plan
- **Reset and run:**
  - Stimulus: TICK_DIV=4, DB_CYCLES=3, rst, then a clean ss press.
  - Required: `data`=0000 and `running`=0 after reset. `running`=1 at k+6. `data` then increments 0001, 0002, … once every 4 cycles.
- **Carry and wrap:**
  - Run 9999 ticks → `data`=9999 with every nibble ≤9.
  - One more tick → `data`=0000 with `running` still 1.
  - Also check the intermediate carries 0099→0100 and 0999→1000.
- **Debounce:**
  - 2-cycle raw pulses on ss → no state change.
  - A 6-cycle chatter burst followed by a stable press → exactly one event.
  - A release → no event.
- **Lap:**
  - Press lap at live 0012 → `data` holds 0012 while the live count advances.
  - Second lap press → `data` jumps to the current live value (e.g. 0030) and `lapped`=0.
- **Stop, resume, clear:**
  - Stop at 0042 → `data` holds 0042. Press clr in RUN before stopping → ignored.
  - Resume → continues from 0042, with the first tick landing after the held prescaler remainder.
  - Stop, then clr → `data`=0000, IDLE, `lapped`=0.
- **Simultaneous events and reset mid-operation:**
  - clr and ss events in the same cycle in STOP → IDLE.
  - `rst` asserted while RUN with `lapped`=1 → all outputs 0 the next cycle.

Source files
------------

// File: rtl/stopwatch_bcd_if.sv
// Button inputs and display-side outputs of the stopwatch core.
// master drives the buttons; slave is the stopwatch itself.
interface stopwatch_bcd_if;
  logic        btn_ss;
  logic        btn_lap;
  logic        btn_clr;
  logic [15:0] data;
  logic        running;
  logic        lapped;

  modport master (output btn_ss, btn_lap, btn_clr, input data, running, lapped);
  modport slave  (input btn_ss, btn_lap, btn_clr, output data, running, lapped);
endinterface

// File: rtl/stopwatch_bcd.sv
// Stopwatch core: synchronised, debounced buttons driving a four-digit BCD
// SS.hh counter with start/stop, lap freeze and clear.
module stopwatch_bcd #(
  parameter int unsigned TICK_DIV  = 1_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input logic            clk,
  input logic            rst,
  stopwatch_bcd_if.slave sw
);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam int unsigned BSS  = 0;
  localparam int unsigned BLAP = 1;
  localparam int unsigned BCLR = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  logic [2:0]          raw, sync1_q, sync2_q, lvl_q, lvl_d, prev_q, ev;
  logic [2:0][CW-1:0]  dbc_q, dbc_d;
  state_t              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [15:0]         live_q, live_d, lap_q, lap_d, data_q;
  logic                lapped_q, lapped_d, tick;

  assign raw = {sw.btn_clr, sw.btn_lap, sw.btn_ss};

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Counter tracks consecutive cycles of disagreement with the debounced level.
  always_comb begin
    lvl_d = lvl_q;
    dbc_d = dbc_q;
    for (int unsigned b = 0; b < 3; b++) begin
      if (sync2_q[b] != lvl_q[b]) begin
        if (dbc_q[b] == CW'(DB_CYCLES - 1)) begin
          lvl_d[b] = sync2_q[b];
          dbc_d[b] = '0;
        end else begin
          dbc_d[b] = dbc_q[b] + CW'(1);
        end
      end else begin
        dbc_d[b] = '0;
      end
    end
  end

  assign ev = lvl_q & ~prev_q;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    live_d   = live_q;
    lap_d    = lap_q;
    lapped_d = lapped_q;
    tick     = 1'b0;

    if (state_q == S_RUN) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (tick) live_d = bcd_inc(live_q);

    // A clr event swallows same-cycle ss/lap even when it is itself ignored in RUN.
    if (ev[BCLR]) begin
      if (state_q != S_RUN) begin
        state_d  = S_IDLE;
        presc_d  = '0;
        live_d   = '0;
        lap_d    = '0;
        lapped_d = 1'b0;
      end
    end else if (ev[BSS]) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          presc_d = '0;
        end
        S_RUN:   state_d = S_STOP;
        S_STOP:  state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end else if (ev[BLAP]) begin
      if (state_q == S_RUN) begin
        lapped_d = ~lapped_q;
        if (!lapped_q) lap_d = live_q;
      end else if (state_q == S_STOP) begin
        lapped_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      lvl_q    <= '0;
      prev_q   <= '0;
      dbc_q    <= '0;
      state_q  <= S_IDLE;
      presc_q  <= '0;
      live_q   <= '0;
      lap_q    <= '0;
      lapped_q <= 1'b0;
      data_q   <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      lvl_q    <= lvl_d;
      prev_q   <= lvl_q;
      dbc_q    <= dbc_d;
      state_q  <= state_d;
      presc_q  <= presc_d;
      live_q   <= live_d;
      lap_q    <= lap_d;
      lapped_q <= lapped_d;
      data_q   <= lapped_q ? lap_q : live_q;
    end
  end

  assign sw.data    = data_q;
  assign sw.running = (state_q == S_RUN);
  assign sw.lapped  = lapped_q;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Randomised stimulus against an integer-count reference model; every cycle's
// expected outputs are queued and compared by an independent monitor.
module tb_stopwatch_bcd;
  localparam int TD = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stopwatch_bcd_if sw ();

  stopwatch_bcd #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        r;
    logic        l;
  } obs_t;

  obs_t sb_q[$];
  bit   armed = 1'b0;

  // Model keeps elapsed time as an integer number of hundredths.
  int m_s1[3], m_s2[3], m_lvl[3], m_prev[3], m_run[3];
  int m_mode;  // 0 idle, 1 run, 2 stop
  int m_count, m_phase, m_frozen, m_lap, m_disp;

  function automatic logic [15:0] to_bcd(int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  always @(posedge clk) begin
    int raw[3];
    int ev[3];
    int nc, np;
    raw[0] = int'(sw.btn_ss);
    raw[1] = int'(sw.btn_lap);
    raw[2] = int'(sw.btn_clr);
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_prev[b] = 0; m_run[b] = 0;
      end
      m_mode = 0; m_count = 0; m_phase = 0; m_frozen = 0; m_lap = 0; m_disp = 0;
      armed = 1'b1;
    end else if (armed) begin
      for (int b = 0; b < 3; b++) ev[b] = (m_lvl[b] == 1 && m_prev[b] == 0) ? 1 : 0;
      m_disp = (m_frozen != 0) ? m_lap : m_count;
      nc = m_count;
      np = m_phase;
      if (m_mode == 1) begin
        if (m_phase == TD - 1) begin
          nc = (m_count + 1) % 10000;
          np = 0;
        end else begin
          np = m_phase + 1;
        end
      end
      if (ev[2] != 0) begin
        if (m_mode != 1) begin
          m_mode = 0; nc = 0; np = 0; m_frozen = 0; m_lap = 0;
        end
      end else if (ev[0] != 0) begin
        if (m_mode == 0) begin
          m_mode = 1;
          np = 0;
        end else if (m_mode == 1) begin
          m_mode = 2;
        end else begin
          m_mode = 1;
        end
      end else if (ev[1] != 0) begin
        if (m_mode == 1) begin
          if (m_frozen == 0) m_lap = m_count;
          m_frozen = (m_frozen == 0) ? 1 : 0;
        end else if (m_mode == 2) begin
          m_frozen = 0;
        end
      end
      m_count = nc;
      m_phase = np;
      for (int b = 0; b < 3; b++) begin
        m_prev[b] = m_lvl[b];
        if (m_s2[b] != m_lvl[b]) m_run[b]++;
        else m_run[b] = 0;
        if (m_run[b] == DB) begin
          m_lvl[b] = m_s2[b];
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
    if (armed) sb_q.push_back({to_bcd(m_disp), (m_mode == 1), (m_frozen != 0)});
  end

  always @(negedge clk) begin
    obs_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if (sw.data !== e.d || sw.running !== e.r || sw.lapped !== e.l) begin
        n_err++;
        $display("FAIL scoreboard t=%0t actual data=%h running=%b lapped=%b required data=%h running=%b lapped=%b",
                 $time, sw.data, sw.running, sw.lapped, e.d, e.r, e.l);
      end
    end
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_data(logic [15:0] val, int budget);
    int i = 0;
    while (sw.data !== val && i < budget) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("reach_%h", val), sw.data, val);
  endtask

  task automatic wait_change(logic [15:0] from, logic [15:0] req, int budget);
    int i = 0;
    while (sw.data === from && i < budget) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("after_%h", from), sw.data, req);
  endtask

  task automatic press(logic [2:0] mask, int hold);
    @(posedge clk);
    #1 {sw.btn_clr, sw.btn_lap, sw.btn_ss} = mask;
    repeat (hold) @(posedge clk);
    #1 {sw.btn_clr, sw.btn_lap, sw.btn_ss} = 3'b000;
    repeat (DB + 4) @(posedge clk);
  endtask

  task automatic pulse(logic [2:0] mask, int len);
    @(posedge clk);
    #1 {sw.btn_clr, sw.btn_lap, sw.btn_ss} = mask;
    repeat (len) @(posedge clk);
    #1 {sw.btn_clr, sw.btn_lap, sw.btn_ss} = 3'b000;
    repeat (DB + 4) @(posedge clk);
  endtask

  task automatic chatter_press();
    logic [5:0] pat = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      @(posedge clk);
      #1 sw.btn_ss = pat[i];
    end
    repeat (DB + 2) @(posedge clk);
    #1 sw.btn_ss = 1'b0;
    repeat (DB + 4) @(posedge clk);
  endtask

  initial begin
    sw.btn_ss = 1'b0; sw.btn_lap = 1'b0; sw.btn_clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_data", sw.data, 16'h0000);
    check("reset_running", {15'b0, sw.running}, 16'h0000);

    // Clean start press: running must rise exactly 6 cycles after the step.
    @(posedge clk);
    #1 sw.btn_ss = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("running_k5", {15'b0, sw.running}, 16'h0000);
    @(posedge clk);
    #1 check("running_k6", {15'b0, sw.running}, 16'h0001);
    repeat (4) @(posedge clk);
    #1 sw.btn_ss = 1'b0;
    repeat (DB + 4) @(posedge clk);

    wait_data(16'h0012, 200);
    press(3'b010, DB + 2);
    repeat (40) @(posedge clk);
    press(3'b010, DB + 2);
    press(3'b100, DB + 2);
    pulse(3'b001, 2);
    pulse(3'b001, 2);

    wait_data(16'h0040, 200);
    press(3'b010, DB + 2);
    press(3'b001, DB + 2);
    repeat (30) @(posedge clk);
    press(3'b010, DB + 2);
    pulse(3'b001, 2);
    chatter_press();

    wait_data(16'h0099, 600);
    wait_change(16'h0099, 16'h0100, 2 * TD + 2);
    wait_data(16'h0999, 4000);
    wait_change(16'h0999, 16'h1000, 2 * TD + 2);
    wait_data(16'h9999, 40000);
    wait_change(16'h9999, 16'h0000, 2 * TD + 2);
    check("running_after_wrap", {15'b0, sw.running}, 16'h0001);

    press(3'b001, DB + 2);
    press(3'b101, DB + 2);
    check("clr_ss_data", sw.data, 16'h0000);
    check("clr_ss_running", {15'b0, sw.running}, 16'h0000);
    check("clr_ss_lapped", {15'b0, sw.lapped}, 16'h0000);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0, 1: press(3'($urandom_range(1, 7)), DB + int'($urandom_range(0, 4)));
        2:    pulse(3'($urandom_range(1, 7)), int'($urandom_range(1, DB - 1)));
        3:    chatter_press();
        4:    repeat ($urandom_range(1, 40)) @(posedge clk);
        default: press(3'b001, DB + 1);
      endcase
    end

    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    press(3'b001, DB + 2);
    repeat (20) @(posedge clk);
    press(3'b010, DB + 2);
    check("pre_rst_lapped", {15'b0, sw.lapped}, 16'h0001);
    check("pre_rst_running", {15'b0, sw.running}, 16'h0001);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_data", sw.data, 16'h0000);
    check("rst_mid_running", {15'b0, sw.running}, 16'h0000);
    check("rst_mid_lapped", {15'b0, sw.lapped}, 16'h0000);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
